// File: rtl/c3aibadapt_srrst_pkg.sv
// Shared types and limits for the SR/adapter sequenced reset-release block.
// Exports: state_t (S_RST/S_WAIT/S_DONE), MAX_CH, IDX_W.
package c3aibadapt_srrst_pkg;

  localparam int MAX_CH = 16;
  // One extra bit so "idx + 1" past the last channel never wraps.
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/c3aibadapt_srrst_nextch.sv
// Priority search: lowest enabled channel index >= i_from.
// Ports: i_en (per-channel enable), i_from, o_idx, o_none.
module c3aibadapt_srrst_nextch
  import c3aibadapt_srrst_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0] i_en,
  input  logic [IDX_W-1:0]  i_from,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_none
);

  // Scan downwards so the lowest qualifying index wins.
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_en[i] && (IDX_W'(i) >= i_from)) begin
        o_idx  = IDX_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/c3lib_rstsync.sv
// Reset-style synchroniser: flop chain cleared to RESET_VAL by rst_n.
// Ports: clk, rst_n, rst_n_bypass, scan_mode_n, data_in, data_out.
module c3lib_rstsync #(
  parameter int   NUM_STAGES = 2,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_n_bypass,
  input  logic scan_mode_n,
  input  logic data_in,
  output logic data_out
);

  logic [NUM_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {NUM_STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[NUM_STAGES-2:0], data_in};
    end
  end

  // In scan the bypass value replaces the synchronised output.
  assign data_out = scan_mode_n ? r_chain[NUM_STAGES-1]
                                : rst_n_bypass;

endmodule

// File: rtl/c3aibadapt_srrst_seq.sv
// Sequenced per-channel reset release with stagger, scan bypass, status.
// Optional macro C3AIBADAPT_SRRST_FREE_RUN_EN adds port r_sr_free_run.
module c3aibadapt_srrst_seq
  import c3aibadapt_srrst_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_rdy_dly_in,
  input  logic              dft_adpt_rst,
  input  logic              adapter_scan_mode_n,
  input  logic              adapter_scan_rst_n,
  input  logic [NUM_CH-1:0] r_sr_ch_en,
  input  logic [CNT_W-1:0]  r_sr_stagger_dly,
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
  input  logic [NUM_CH-1:0] r_sr_free_run,
`endif
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              seq_busy,
  output logic              seq_done
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_CH-1:0]  r_ch;
  logic               r_busy;
  logic               r_done;

  logic               w_hrd_rst_n;
  logic               w_hrd_sync;
  logic [IDX_W-1:0]   w_from;
  logic [IDX_W-1:0]   w_nidx;
  logic               w_none;
  logic [NUM_CH-1:0]  w_rel;
  logic [NUM_CH-1:0]  w_byp;

  assign w_hrd_rst_n = csr_rdy_dly_in & ~dft_adpt_rst;

  c3lib_rstsync #(
    .NUM_STAGES (SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_hrd_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_n_bypass (rst_n),
    .scan_mode_n  (1'b1),
    .data_in      (w_hrd_rst_n),
    .data_out     (w_hrd_sync)
  );

  // Start search from 0 when launching, else strictly above idx.
  assign w_from = (r_state == S_RST) ? '0 : r_idx + IDX_W'(1);

  c3aibadapt_srrst_nextch #(
    .NUM_CH (NUM_CH)
  ) u_nextch (
    .i_en   (r_sr_ch_en),
    .i_from (w_from),
    .o_idx  (w_nidx),
    .o_none (w_none)
  );

  always_comb begin
    w_rel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rel[i] = (r_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ch    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!w_hrd_sync) begin
      // Reset assertion is immediate for every channel.
      r_state <= S_RST;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ch    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RST: begin
          r_ch  <= '0;
          r_cnt <= '0;
          r_idx <= w_nidx;
          if (w_none) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == r_sr_stagger_dly) begin
            r_ch  <= (r_ch | w_rel) & r_sr_ch_en;
            r_cnt <= '0;
            r_idx <= w_nidx;
            if (w_none) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_ch  <= r_ch & r_sr_ch_en;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_ch <= r_ch & r_sr_ch_en;
        end
        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
  // Free-running channels keep their sequenced reset in scan.
  assign w_byp = adapter_scan_mode_n ? '0 : ~r_sr_free_run;
`else
  assign w_byp = adapter_scan_mode_n ? '0 : '1;
`endif

  assign ch_rst_n = (w_byp & {NUM_CH{adapter_scan_rst_n}})
                  | (~w_byp & r_ch);
  assign seq_busy = r_busy & adapter_scan_mode_n;
  assign seq_done = r_done & adapter_scan_mode_n;

endmodule

// File: tb/tb_c3aibadapt_srrst_seq.sv
// Self-checking bench for c3aibadapt_srrst_seq (NUM_CH=3, SYNC_STAGES=2).
// Ports driven directly; optional r_sr_free_run connected under macro.
module tb_c3aibadapt_srrst_seq;

  localparam int N  = 3;
  localparam int CW = 4;
  localparam int SS = 2;

  logic          clk;
  logic          rst_n;
  logic          csr_rdy_dly_in;
  logic          dft_adpt_rst;
  logic          adapter_scan_mode_n;
  logic          adapter_scan_rst_n;
  logic [N-1:0]  r_sr_ch_en;
  logic [CW-1:0] r_sr_stagger_dly;
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
  logic [N-1:0]  r_sr_free_run;
`endif
  logic [N-1:0]  ch_rst_n;
  logic          seq_busy;
  logic          seq_done;

  int checks;
  int errors;

  c3aibadapt_srrst_seq #(
    .NUM_CH      (N),
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .csr_rdy_dly_in      (csr_rdy_dly_in),
    .dft_adpt_rst        (dft_adpt_rst),
    .adapter_scan_mode_n (adapter_scan_mode_n),
    .adapter_scan_rst_n  (adapter_scan_rst_n),
    .r_sr_ch_en          (r_sr_ch_en),
    .r_sr_stagger_dly    (r_sr_stagger_dly),
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
    .r_sr_free_run       (r_sr_free_run),
`endif
    .ch_rst_n            (ch_rst_n),
    .seq_busy            (seq_busy),
    .seq_done            (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  en;
    logic [CW-1:0] dly;
    int            done_edge;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Model: j-th enabled channel (ascending) released at
  // edge SS+2+D+j*(D+1); done at last release or SS+1 if none.
  task automatic model_rel(input logic [N-1:0] en, input int d,
                           output int rel[N], output int last);
    int j;
    j    = 0;
    last = SS + 1;
    for (int k = 0; k < N; k++) begin
      rel[k] = 1 << 30;
      if (en[k]) begin
        rel[k] = SS + 2 + d + j * (d + 1);
        last   = rel[k];
        j++;
      end
    end
  endtask

  // Launch a sequence; check every edge up to stop_edge.
  // Returns the observed first edge with seq_done=1.
  task automatic run_seq(input logic [N-1:0] en, input logic [CW-1:0] dly,
                         input int stop_edge, output int seen_done);
    int rel[N];
    int last;
    logic [N-1:0] ech;
    logic         eb;
    logic         ed;
    csr_rdy_dly_in = 1'b0;
    dft_adpt_rst   = 1'b0;
    repeat (SS + 3) @(posedge clk);
    #1;
    r_sr_ch_en       = en;
    r_sr_stagger_dly = dly;
    csr_rdy_dly_in   = 1'b1;
    model_rel(en, int'(dly), rel, last);
    seen_done = -1;
    for (int e = 1; e <= stop_edge; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) ech[k] = en[k] && (e >= rel[k]);
      eb = (en != '0) && (e >= SS + 1) && (e < last);
      ed = (e >= last);
      chk($sformatf("seq_en%b_d%0d_e%0d", en, dly, e),
          {27'd0, ch_rst_n, seq_busy, seq_done},
          {27'd0, ech, eb, ed});
      if (seq_done && seen_done < 0) seen_done = e;
    end
  endtask

  int dn;
  int rel_r[N];
  int last_r;

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{3'b111, 4'd2,  12};
    tbl[1] = '{3'b101, 4'd0,  5};
    tbl[2] = '{3'b000, 4'd5,  3};
    tbl[3] = '{3'b001, 4'd15, 19};
    tbl[4] = '{3'b100, 4'd3,  7};
    tbl[5] = '{3'b110, 4'd1,  7};

    rst_n               = 1'b0;
    csr_rdy_dly_in      = 1'b1;
    dft_adpt_rst        = 1'b0;
    adapter_scan_mode_n = 1'b1;
    adapter_scan_rst_n  = 1'b0;
    r_sr_ch_en          = 3'b111;
    r_sr_stagger_dly    = 4'd0;
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
    r_sr_free_run       = 3'b000;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {29'd0, ch_rst_n, seq_busy, seq_done}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_seq(tbl[i].en, tbl[i].dly, tbl[i].done_edge + 3, dn);
      chk($sformatf("done_edge_%0d", i), dn, tbl[i].done_edge);
    end

    // dft reset mid-sequence: all channels low within SS+1 edges.
    run_seq(3'b111, 4'd2, 7, dn);
    dft_adpt_rst = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    chk("dft_clear", {29'd0, ch_rst_n, seq_busy, seq_done}, 32'd0);
    run_seq(3'b111, 4'd2, 14, dn);
    chk("dft_reseq_done", dn, 12);

    // Clear en[1] after done, then re-enable: stays in reset.
    r_sr_ch_en = 3'b101;
    @(posedge clk);
    #1;
    chk("en1_clear", {29'd0, ch_rst_n}, 32'd5);
    r_sr_ch_en = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("en1_reset_stays", {29'd0, ch_rst_n}, 32'd5);
    chk("en1_still_done", {31'd0, seq_done}, 32'd1);

    // Scan bypass, sequencer already done with ch=111.
    r_sr_ch_en = 3'b111;
    run_seq(3'b111, 4'd0, 8, dn);
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
    r_sr_free_run = 3'b010;
`endif
    adapter_scan_mode_n = 1'b0;
    for (int t = 0; t < 4; t++) begin
      adapter_scan_rst_n = t[0];
      #1;
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
      chk($sformatf("scan_%0d", t), {28'd0, ch_rst_n, seq_done},
          {28'd0, t[0], 1'b1, t[0], 1'b0});
`else
      chk($sformatf("scan_%0d", t), {28'd0, ch_rst_n, seq_done},
          {28'd0, {N{t[0]}}, 1'b0});
`endif
      chk($sformatf("scan_busy_%0d", t), {31'd0, seq_busy}, 32'd0);
      #3;
    end
    adapter_scan_mode_n = 1'b1;
`ifdef C3AIBADAPT_SRRST_FREE_RUN_EN
    r_sr_free_run = 3'b000;
`endif
    #1;
    chk("scan_exit", {28'd0, ch_rst_n, seq_done}, 32'hF);

    // Randomised sequences against the formula model.
    for (int r = 0; r < 10; r++) begin
      logic [N-1:0]  en;
      logic [CW-1:0] d;
      en = N'($urandom_range(0, 7));
      d  = CW'($urandom_range(0, 15));
      model_rel(en, int'(d), rel_r, last_r);
      run_seq(en, d, last_r + 2, dn);
      chk($sformatf("rnd_done_%0d", r), dn, last_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
